// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with prefetch queue, redirect flush and IF/ID register
// Ports:
//   CLK, RESn          clock, asynchronous active-low reset
//   HLT                stall: hold IF_ID outputs, no pop
//   branch_taken/target redirect fetch to branch_target at next edge
//   imem_req/addr/ready fetch request handshake (word aligned address)
//   imem_rvalid/rdata  in-order responses
//   IF_ID_pc/inst      presented instruction, inst 0 is a bubble
//   perf_fetched/flushed  (only with FETCH_PERF_CNT_EN) kept / flushed response counters
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        HLT,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);

    logic [31:0] fpc_q, fpc_d, rsp_pc_q, rsp_pc_d, if_pc_q, if_pc_d, if_inst_q, if_inst_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, disc_q, disc_d;
    logic [31:0] qpc_q [QUEUE_DEPTH];
    logic [31:0] qpc_d [QUEUE_DEPTH];
    logic [31:0] qinst_q [QUEUE_DEPTH];
    logic [31:0] qinst_d [QUEUE_DEPTH];
    logic accept, rsp_valid, rsp_keep, rsp_drop, push, pop;

    // queued + in-flight never exceeds the queue size, so a response always has room
    assign imem_req   = RESn && (({1'b0, cnt_q} + {1'b0, out_q}) < {1'b0, DEPTH});
    assign imem_addr  = fpc_q;
    assign IF_ID_pc   = if_pc_q;
    assign IF_ID_inst = if_inst_q;
    assign accept     = imem_req && imem_ready;
    // responses with nothing outstanding (e.g. for pre-reset requests) are ignored
    assign rsp_valid  = imem_rvalid && (out_q != '0);
    assign rsp_drop   = rsp_valid && (disc_q != '0);
    assign rsp_keep   = rsp_valid && (disc_q == '0);

    always_comb begin
        fpc_d     = accept ? fpc_q + 32'd4 : fpc_q;
        // responses are in order, so the pc of the next kept response is tracked with one register
        rsp_pc_d  = rsp_keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
        out_d     = out_q + CW'(accept) - CW'(rsp_valid);
        disc_d    = disc_q - CW'(rsp_drop);
        if_pc_d   = if_pc_q;
        if_inst_d = if_inst_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        qpc_d     = qpc_q;
        qinst_d   = qinst_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (branch_taken) begin
            fpc_d     = branch_target & ~32'h3;
            rsp_pc_d  = branch_target & ~32'h3;
            // everything still in flight after this edge, including a same-cycle accept, is stale
            disc_d    = out_d;
            cnt_d     = '0;
            rd_d      = '0;
            wr_d      = '0;
            if_inst_d = 32'h0;
        end else begin
            pop  = !HLT && (cnt_q != '0);
            push = rsp_keep && (HLT || (cnt_q != '0));
            if (!HLT) begin
                if (pop) begin
                    if_pc_d   = qpc_q[rd_q];
                    if_inst_d = qinst_q[rd_q];
                end else if (rsp_keep) begin
                    if_pc_d   = rsp_pc_q;
                    if_inst_d = imem_rdata;
                end else begin
                    if_inst_d = 32'h0;
                end
            end
            if (push) begin
                qpc_d[wr_q]   = rsp_pc_q;
                qinst_d[wr_q] = imem_rdata;
            end
            wr_d  = wr_q + PW'(push);
            rd_d  = rd_q + PW'(pop);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            fpc_q     <= RESET_PC & ~32'h3;
            rsp_pc_q  <= RESET_PC & ~32'h3;
            if_pc_q   <= RESET_PC;
            if_inst_q <= 32'h0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            disc_q    <= '0;
        end else begin
            fpc_q     <= fpc_d;
            rsp_pc_q  <= rsp_pc_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
        end
    end

    always_ff @(posedge CLK) begin
        qpc_q   <= qpc_d;
        qinst_q <= qinst_d;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_flushed_q, perf_flushed_d;

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;

    // a kept response landing in a redirect cycle is thrown away with the queue, so it counts as flushed
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(rsp_keep && !branch_taken);
        perf_flushed_d = perf_flushed_q + 32'(rsp_drop)
                       + (branch_taken ? 32'(cnt_q) + 32'(rsp_keep) : 32'd0);
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end
`endif
endmodule
